alu_issue_unit: RTL
===================

// Module: alu_issue_unit
// PURPOSE
//  Upstream issue stage for the 8-bit combinational ALU (a, b, ctrl -> out, carry).
//  Buffers operation requests in a small command FIFO and presents one command at a time to the ALU.
//  Captures out/carry into a registered result stage with a valid/ready handshake toward the consumer.
//  Decouples producers and consumers from the ALU's combinational timing; one op per clock at full throughput.
// PARAMETERS
//  WIDTH   8  operand/result width; must match the ALU
//  CTRL_W  4  ALU control (opcode) width; 16 ops
//  DEPTH   4  command FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              command offered
//  in_ready   out  1              command FIFO can accept (= !full)
//  in_a       in   WIDTH          operand A
//  in_b       in   WIDTH          operand B
//  in_ctrl    in   CTRL_W         ALU opcode
//  alu_a      out  WIDTH          to ALU a
//  alu_b      out  WIDTH          to ALU b
//  alu_ctrl   out  CTRL_W         to ALU ctrl
//  alu_out    in   WIDTH          from ALU out (combinational)
//  alu_carry  in   1              from ALU carry
//  res_valid  out  1              result register holds an unconsumed result
//  res_ready  in   1              consumer accepts result
//  res_data   out  WIDTH          captured alu_out
//  res_carry  out  1              captured alu_carry
//  res_ctrl   out  CTRL_W         opcode that produced res_data
//  count      out  $clog2(DEPTH+1) current FIFO occupancy
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, count=0, in_ready=1, res_valid=0, res_data/res_carry/res_ctrl=0, alu_*=0, FSM=IDLE.
//    Reset mid-operation drops all queued commands and any pending result; no partial result is ever presented.
//  - Push: in_valid && in_ready at a rising edge. in_ready depends only on full, never on res_ready; no bypass when full.
//  - ALU drive: FIFO head drives alu_a/alu_b/alu_ctrl straight from FIFO storage (registered source). Empty FIFO -> all zero.
//  - Issue: fire = !empty && (!res_valid || res_ready). On fire: res_* <= {alu_out, alu_carry, head ctrl}, res_valid <= 1, pop head.
//    Otherwise, if res_valid && res_ready, res_valid <= 0.
//  - Latency: command pushed at edge N is head from N; result visible after edge N+1 (empty FIFO, idle output).
//    Throughput: 1 result/clk while res_ready=1.
//  - FSM (status/debug; the datapath follows the fire rule):
//    IDLE  : empty && !res_valid
//    RUN   : fire this cycle
//    STALL : !empty && res_valid && !res_ready; head and alu_* held stable
//    DRAIN : empty && res_valid
//    Next state is computed from next-cycle occupancy/res_valid.
//  - Simultaneous push+pop: allowed when not full; count unchanged. Push into empty FIFO with pop not possible same edge (no fall-through).
//  - Pointers: log2(DEPTH) bits, wrap modulo DEPTH; full/empty derived from count.
//  - Widths: result is exactly WIDTH+1 bits from ALU; no extension or truncation inside this block.
//  - res_* remain stable while res_valid && !res_ready.
// STRUCTURE
//  - alu_pkg: WIDTH/CTRL_W constants, 16 opcode localparams (4'h0..4'hF), FSM state encoding
//    (IDLE=2'd0, RUN=2'd1, STALL=2'd2, DRAIN=2'd3).
//  - Sub-module: sync_fifo (WIDTH*2+CTRL_W wide, DEPTH deep, push/pop/full/empty/count).
//    Issue logic, result register and FSM live in this module.
// TESTING  (bench instantiates the real ALU between alu_* ports)
//  1. Reset then idle: rst_n=0 mid-run -> res_valid=0, count=0, in_ready=1, alu_*=0, state IDLE.
//  2. Single op: a=8'hFF, b=8'hFF, ctrl=4'h0, res_ready=1 -> res_valid 1 clk after push;
//     res_data/res_carry match ALU for ctrl 0; res_ctrl=4'h0.
//  3. Opcode sweep: a=b=8'hFF, ctrl 4'h0..4'hF back-to-back, res_ready=1 ->
//     16 results in order on 16 consecutive cycles, each equal to the ALU model.
//  4. Backpressure: res_ready=0, push 5 ops -> count saturates at 4, in_ready=0, state STALL,
//     res_* and alu_* frozen; raise res_ready -> 5 results in order, no loss or duplication.
//  5. Full with push+pop: count=4, res_ready=1, in_valid=1 -> no push while full;
//     next cycle push+pop together keeps count=3..4 and pointers wrap correctly.
//  6. Reset mid-stall: 3 queued, res_valid=1, rst_n pulsed low ->
//     all outputs return to reset values immediately; next push a=8'h01, b=8'h02 returns only its own result.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU opcodes and issue FSM encoding
package alu_pkg;

    localparam int ALU_WIDTH  = 8;
    localparam int ALU_CTRL_W = 4;
    localparam int FIFO_DEPTH = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } issue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO without fall-through; empty reads as zero
module sync_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers are log2(DEPTH) wide, so wrap-around is the natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - command FIFO, issue logic and registered result stage in front of the ALU
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int CTRL_W = ALU_CTRL_W,
    parameter int DEPTH  = FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_carry,
    output logic [CTRL_W-1:0] res_ctrl,
    output logic [CNT_W-1:0]  count,
    output logic [1:0]        state
);

    localparam int CMD_W = 2 * WIDTH + CTRL_W;

    logic [CMD_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_fire;
    logic              w_next_rv;
    logic              w_next_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_next_count;

    logic              r_res_valid;
    logic [WIDTH-1:0]  r_res_data;
    logic              r_res_carry;
    logic [CTRL_W-1:0] r_res_ctrl;
    issue_state_t      r_state;

    sync_fifo #(
        .DW    (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata ({in_a, in_b, in_ctrl}),
        .pop   (w_fire),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_push   = in_valid && !w_full;
    assign w_fire   = !w_empty && (!r_res_valid || res_ready);
    assign in_ready = !w_full;

    assign {alu_a, alu_b, alu_ctrl} = w_head;

    assign w_next_rv    = w_fire || (r_res_valid && !res_ready);
    assign w_next_count = w_count + CNT_W'(w_push) - CNT_W'(w_fire);
    assign w_next_empty = (w_next_count == '0);

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_ctrl  = r_res_ctrl;
    assign count     = w_count;
    assign state     = r_state;

    // Status predicts the coming cycle; a pending result with the consumer
    // currently not ready is reported as STALL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_ctrl  <= '0;
            r_state     <= ST_IDLE;
        end else begin
            if (w_fire) begin
                r_res_data  <= alu_out;
                r_res_carry <= alu_carry;
                r_res_ctrl  <= alu_ctrl;
                r_res_valid <= 1'b1;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end

            if (w_next_empty) begin
                r_state <= w_next_rv ? ST_DRAIN : ST_IDLE;
            end else if (!w_next_rv || res_ready) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_STALL;
            end
        end
    end

endmodule
